// File: rtl/tcbm_pio_hs_if.sv
// Host-side bus of the TCBM paddle PIO: decoder strobe, register window and interrupt.
interface tcbm_pio_hs_if;
    logic       bus_sel;
    logic       bus_we;
    logic [2:0] bus_rs;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       irq;

    modport master (output bus_sel, output bus_we, output bus_rs, output bus_wdata,
                    input  bus_rdata, input irq);
    modport slave  (input  bus_sel, input  bus_we, input  bus_rs, input  bus_wdata,
                    output bus_rdata, output irq);
endinterface

// File: rtl/tcbm_pio_hs.sv
// 6523-style three-port PIO with a DAV/ACK byte-handshake engine on ports A/C.
// Define HS_TIMEOUT_EN to bound the handshake waits by TIMEOUT_CYCLES.
module tcbm_pio_hs #(
    parameter int PA_WIDTH       = 8,
    parameter int PB_WIDTH       = 2,
    parameter int PC_WIDTH       = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                clock,
    input  logic                reset,
    tcbm_pio_hs_if.slave        bus,
    input  logic [PA_WIDTH-1:0] pa_in,
    output logic [PA_WIDTH-1:0] pa_out,
    output logic [PA_WIDTH-1:0] pa_oe,
    input  logic [PB_WIDTH-1:0] pb_in,
    output logic [PB_WIDTH-1:0] pb_out,
    output logic [PB_WIDTH-1:0] pb_oe,
    input  logic [PC_WIDTH-1:0] pc_in,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic [PC_WIDTH-1:0] pc_oe
);

    typedef enum logic [3:0] {
        IDLE, SETUP, ASSERT, WAIT_ACK, RELEASE, WAIT_ACKR, DONE,
        R_WAIT, R_ACK, R_REL
    } hs_state_t;

    hs_state_t state, next_state;

    logic [PA_WIDTH-1:0] pa_sync [SYNC_STAGES];
    logic [PB_WIDTH-1:0] pb_sync [SYNC_STAGES];
    logic [PC_WIDTH-1:0] pc_sync [SYNC_STAGES];
    logic [PA_WIDTH-1:0] pa_s;
    logic [PB_WIDTH-1:0] pb_s;
    logic [PC_WIDTH-1:0] pc_s;

    logic [PA_WIDTH-1:0] pra, ddra, rxa;
    logic [PB_WIDTH-1:0] prb, ddrb;
    logic [PC_WIDTH-1:0] prc, ddrc;
    logic                hs_en, hs_rx;
    logic                done, timeout;
    logic                sel_d;
    logic [7:0]          rdata_r;

    logic       access, rd_access, pra_wr, busy, ack_s;
    logic       dav_eng, set_done, set_to, latch_rx, to_hit;
    logic       clr_done, clr_to;
    logic [7:0] rd_val;

    // Every pin input crosses SYNC_STAGES flops before any logic looks at it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                pa_sync[i] <= '0;
                pb_sync[i] <= '0;
                pc_sync[i] <= '0;
            end
        end else begin
            pa_sync[0] <= pa_in;
            pb_sync[0] <= pb_in;
            pc_sync[0] <= pc_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                pa_sync[i] <= pa_sync[i-1];
                pb_sync[i] <= pb_sync[i-1];
                pc_sync[i] <= pc_sync[i-1];
            end
        end
    end

    assign pa_s  = pa_sync[SYNC_STAGES-1];
    assign pb_s  = pb_sync[SYNC_STAGES-1];
    assign pc_s  = pc_sync[SYNC_STAGES-1];
    assign ack_s = pc_s[PC_WIDTH-2];

    assign access    = bus.bus_sel & ~sel_d;
    assign rd_access = access & ~bus.bus_we;
    assign pra_wr    = access & bus.bus_we & (bus.bus_rs == 3'd0);
    assign busy      = (state != IDLE) && (state != R_WAIT);
    assign clr_done  = rd_access & ((bus.bus_rs == 3'd7) ||
                                    ((bus.bus_rs == 3'd0) && hs_en && hs_rx));
    assign clr_to    = rd_access & (bus.bus_rs == 3'd7);

`ifdef HS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    logic          wait_state;

    assign wait_state = (state == WAIT_ACK) || (state == WAIT_ACKR) || (state == R_ACK);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if (next_state != state)
            wait_cnt <= '0;
        else if (wait_state)
            wait_cnt <= wait_cnt + 1'b1;
    end

    // Fires on the cycle whose closing edge would bring the count to TIMEOUT_CYCLES
    assign to_hit = wait_state && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        dav_eng    = 1'b1;
        set_done   = 1'b0;
        set_to     = 1'b0;
        latch_rx   = 1'b0;
        case (state)
            IDLE: begin
                if (hs_en && hs_rx)
                    next_state = R_WAIT;
                else if (hs_en && pra_wr)
                    next_state = SETUP;
            end
            SETUP:  next_state = ASSERT;
            ASSERT: begin
                dav_eng    = 1'b0;
                next_state = WAIT_ACK;
            end
            WAIT_ACK: begin
                dav_eng = 1'b0;
                if (!ack_s) begin
                    next_state = RELEASE;
                end else if (to_hit) begin
                    next_state = IDLE;
                    set_to     = 1'b1;
                end
            end
            RELEASE: next_state = WAIT_ACKR;
            WAIT_ACKR: begin
                if (ack_s) begin
                    next_state = DONE;
                end else if (to_hit) begin
                    next_state = IDLE;
                    set_to     = 1'b1;
                end
            end
            DONE: begin
                set_done   = 1'b1;
                next_state = IDLE;
            end
            R_WAIT: begin
                if (!ack_s && !done) begin
                    latch_rx   = 1'b1;
                    next_state = R_ACK;
                end
            end
            R_ACK: begin
                dav_eng = 1'b0;
                if (ack_s) begin
                    next_state = R_REL;
                end else if (to_hit) begin
                    next_state = R_WAIT;
                    set_to     = 1'b1;
                end
            end
            R_REL: begin
                set_done   = 1'b1;
                next_state = R_WAIT;
            end
            default: next_state = IDLE;
        endcase
        if (!hs_en) begin
            next_state = IDLE;
            set_done   = 1'b0;
            set_to     = 1'b0;
            latch_rx   = 1'b0;
        end else if (!hs_rx && (state == R_WAIT || state == R_ACK || state == R_REL)) begin
            next_state = IDLE;
        end
    end

    always_comb begin
        rd_val = 8'h00;
        case (bus.bus_rs)
            3'd0: rd_val = (hs_en && hs_rx) ? 8'(rxa) : 8'((pa_s & ~ddra) | (pra & ddra));
            3'd1: rd_val = 8'((pb_s & ~ddrb) | (prb & ddrb));
            3'd2: rd_val = 8'((pc_s & ~ddrc) | (prc & ddrc)) << (8 - PC_WIDTH);
            3'd3: rd_val = 8'(ddra);
            3'd4: rd_val = 8'(ddrb);
            3'd5: rd_val = 8'(ddrc) << (8 - PC_WIDTH);
            3'd6: rd_val = {6'b0, hs_rx, hs_en};
            3'd7: rd_val = {5'b0, timeout, done, busy};
            default: rd_val = 8'h00;
        endcase
    end

    // Register file; a PRA write is dropped while a transfer is in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_d   <= 1'b0;
            pra     <= '0;
            prb     <= '0;
            prc     <= '0;
            ddra    <= '0;
            ddrb    <= '0;
            ddrc    <= '0;
            hs_en   <= 1'b0;
            hs_rx   <= 1'b0;
            rxa     <= '0;
            done    <= 1'b0;
            timeout <= 1'b0;
            rdata_r <= 8'h00;
        end else begin
            sel_d <= bus.bus_sel;
            if (access) begin
                rdata_r <= rd_val;
                if (bus.bus_we) begin
                    case (bus.bus_rs)
                        3'd0: if (!busy) pra <= bus.bus_wdata[PA_WIDTH-1:0];
                        3'd1: prb  <= bus.bus_wdata[PB_WIDTH-1:0];
                        3'd2: prc  <= bus.bus_wdata[7 -: PC_WIDTH];
                        3'd3: ddra <= bus.bus_wdata[PA_WIDTH-1:0];
                        3'd4: ddrb <= bus.bus_wdata[PB_WIDTH-1:0];
                        3'd5: ddrc <= bus.bus_wdata[7 -: PC_WIDTH];
                        3'd6: begin
                            hs_en <= bus.bus_wdata[0];
                            hs_rx <= bus.bus_wdata[1];
                        end
                        default: ;
                    endcase
                end
            end
            if (latch_rx)
                rxa <= pa_s;
            if (set_done)
                done <= 1'b1;
            else if (clr_done)
                done <= 1'b0;
            if (set_to)
                timeout <= 1'b1;
            else if (clr_to)
                timeout <= 1'b0;
        end
    end

    assign bus.bus_rdata = rdata_r;
    assign bus.irq       = done | timeout;

    assign pa_out = pra;
    assign pa_oe  = (hs_en && hs_rx) ? '0 : ddra;
    assign pb_out = prb;
    assign pb_oe  = ddrb;

    // The engine owns DAV (always driven) and ACK (always listened to) while enabled
    always_comb begin
        pc_out = prc;
        pc_oe  = ddrc;
        if (hs_en) begin
            pc_out[PC_WIDTH-1] = dav_eng;
            pc_oe[PC_WIDTH-1]  = 1'b1;
            pc_oe[PC_WIDTH-2]  = 1'b0;
        end
    end

endmodule

// File: tb/tb_tcbm_pio_hs.sv
// Randomized port-register checks against a register/pin model, plus directed handshake scenarios.
module tb_tcbm_pio_hs;
    localparam int TO_CYCLES = 16;

    logic       clock;
    logic       reset;
    logic [7:0] pa_in, pa_out, pa_oe;
    logic [1:0] pb_in, pb_out, pb_oe;
    logic [1:0] pc_in, pc_out, pc_oe;

    int checkCount = 0;
    int failCount  = 0;

    logic [7:0] mPr  [3];
    logic [7:0] mDdr [3];
    logic [7:0] mPin [3];

    tcbm_pio_hs_if bus ();

    tcbm_pio_hs #(
        .PA_WIDTH(8), .PB_WIDTH(2), .PC_WIDTH(2),
        .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO_CYCLES)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .pa_in(pa_in), .pa_out(pa_out), .pa_oe(pa_oe),
        .pb_in(pb_in), .pb_out(pb_out), .pb_oe(pb_oe),
        .pc_in(pc_in), .pc_out(pc_out), .pc_oe(pc_oe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One bus access: select rises on a falling edge, the access fires on the next rising edge
    task automatic applyStimulus(input bit we, input logic [2:0] rs, input logic [7:0] wd,
                                 output logic [7:0] rd);
        @(negedge clock);
        bus.bus_sel   = 1'b1;
        bus.bus_we    = we;
        bus.bus_rs    = rs;
        bus.bus_wdata = wd;
        @(negedge clock);
        bus.bus_sel = 1'b0;
        rd = bus.bus_rdata;
    endtask

    task automatic waitDav(input logic val, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clock);
            #1;
            if (pc_out[1] === val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitIrq(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clock);
            #1;
            if (bus.irq === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [7:0] portMask(input int p);
        case (p)
            0:       return 8'hFF;
            1:       return 8'h03;
            default: return 8'hC0;
        endcase
    endfunction

    function automatic logic [7:0] modelRead(input int r);
        int p;
        p = r % 3;
        if (r < 3)
            return ((mPin[p] & ~mDdr[p]) | (mPr[p] & mDdr[p])) & portMask(p);
        return mDdr[p];
    endfunction

    task automatic drivePins();
        pa_in = mPin[0];
        pb_in = mPin[1][1:0];
        pc_in = mPin[2][7:6];
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] tmp;
        bit         ok;
        int         r;
        int         lowCount;

        bus.bus_sel   = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_rs    = 3'd0;
        bus.bus_wdata = 8'h00;
        pa_in = 8'h00;
        pb_in = 2'b00;
        pc_in = 2'b00;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_oe", {8'h0, pa_oe, 6'h0, pb_oe, 6'h0, pc_oe}, 32'h0);
        checkOutput("rst_irq", bus.irq, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 3'(i), 8'h00, rd);
            checkOutput($sformatf("rst_reg%0d", i), rd, 8'h00);
        end

        $display("[TB] port A read mix");
        applyStimulus(1'b1, 3'd3, 8'hF0, rd);
        applyStimulus(1'b1, 3'd0, 8'hA5, rd);
        pa_in = 8'h3C;
        repeat (4) @(posedge clock);
        applyStimulus(1'b0, 3'd0, 8'h00, rd);
        checkOutput("pra_mix", rd, 8'hAC);
        checkOutput("pa_out", pa_out, 8'hA5);
        checkOutput("pa_oe", pa_oe, 8'hF0);

        $display("[TB] randomized register traffic");
        mPr[0] = 8'hA5; mDdr[0] = 8'hF0; mPin[0] = 8'h3C;
        mPr[1] = 8'h00; mDdr[1] = 8'h00; mPin[1] = 8'h00;
        mPr[2] = 8'h00; mDdr[2] = 8'h00; mPin[2] = 8'h00;
        for (int n = 0; n < 40; n++) begin
            r   = int'($urandom_range(0, 5));
            tmp = 8'($urandom);
            applyStimulus(1'b1, 3'(r), tmp, rd);
            if (r < 3) mPr[r] = tmp & portMask(r);
            else       mDdr[r-3] = tmp & portMask(r - 3);
            for (int p = 0; p < 3; p++) mPin[p] = 8'($urandom) & portMask(p);
            drivePins();
            repeat (4) @(posedge clock);
            r = int'($urandom_range(0, 5));
            applyStimulus(1'b0, 3'(r), 8'h00, rd);
            checkOutput($sformatf("rnd_rd%0d", r), rd, modelRead(r));
            checkOutput("rnd_pins",
                        {pa_out, pa_oe, pb_out, pb_oe, pc_out, pc_oe},
                        {mPr[0], mDdr[0], mPr[1][1:0], mDdr[1][1:0], mPr[2][7:6], mDdr[2][7:6]});
        end

        $display("[TB] transmit handshake");
        applyStimulus(1'b1, 3'd5, 8'h00, rd);
        applyStimulus(1'b1, 3'd2, 8'h00, rd);
        pc_in = 2'b11;
        applyStimulus(1'b1, 3'd6, 8'h01, rd);
        applyStimulus(1'b1, 3'd3, 8'hFF, rd);
        checkOutput("tx_pc_oe", pc_oe, 2'b10);
        applyStimulus(1'b1, 3'd0, 8'h5A, rd);
        checkOutput("tx_setup_dav", pc_out[1], 1'b1);
        checkOutput("tx_data", {pa_out, pa_oe}, {8'h5A, 8'hFF});
        @(posedge clock);
        #1;
        checkOutput("tx_assert_dav", pc_out[1], 1'b0);
        applyStimulus(1'b0, 3'd7, 8'h00, rd);
        checkOutput("tx_busy", rd, 8'h01);
        applyStimulus(1'b1, 3'd0, 8'h11, rd);
        checkOutput("tx_busy_drop", pa_out, 8'h5A);
        repeat (4) @(posedge clock);
        checkOutput("tx_wait_dav", pc_out[1], 1'b0);
        pc_in = 2'b10;
        waitDav(1'b1, 20, ok);
        checkOutput("tx_release_wait", ok, 1'b1);
        repeat (5) @(posedge clock);
        pc_in = 2'b11;
        waitIrq(20, ok);
        checkOutput("tx_irq_wait", ok, 1'b1);
        applyStimulus(1'b0, 3'd7, 8'h00, rd);
        checkOutput("tx_hsstat_done", rd, 8'h02);
        applyStimulus(1'b0, 3'd7, 8'h00, rd);
        checkOutput("tx_hsstat_clr", rd, 8'h00);
        checkOutput("tx_irq_clr", bus.irq, 1'b0);

        $display("[TB] abort by clearing enable");
        applyStimulus(1'b1, 3'd0, 8'h3C, rd);
        waitDav(1'b0, 10, ok);
        checkOutput("ab_dav_low", ok, 1'b1);
        applyStimulus(1'b1, 3'd6, 8'h00, rd);
        @(posedge clock);
        #1;
        checkOutput("ab_pc", {pc_out, pc_oe}, 4'b0000);
        applyStimulus(1'b0, 3'd7, 8'h00, rd);
        checkOutput("ab_hsstat", rd, 8'h00);

        $display("[TB] receive handshake");
        pa_in = 8'h77;
        applyStimulus(1'b1, 3'd6, 8'h03, rd);
        @(posedge clock);
        #1;
        checkOutput("rx_pa_oe", pa_oe, 8'h00);
        checkOutput("rx_idle_dav", pc_out[1], 1'b1);
        pc_in = 2'b10;
        waitDav(1'b0, 20, ok);
        checkOutput("rx_ack1", ok, 1'b1);
        pc_in = 2'b11;
        waitDav(1'b1, 20, ok);
        checkOutput("rx_rel1", ok, 1'b1);
        waitIrq(5, ok);
        checkOutput("rx_irq", ok, 1'b1);
        pa_in = 8'h33;
        pc_in = 2'b10;
        lowCount = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (pc_out[1] !== 1'b1) lowCount++;
        end
        checkOutput("rx_hold_second", lowCount, 0);
        applyStimulus(1'b0, 3'd0, 8'h00, rd);
        checkOutput("rx_byte1", rd, 8'h77);
        waitDav(1'b0, 20, ok);
        checkOutput("rx_ack2", ok, 1'b1);
        pc_in = 2'b11;
        waitDav(1'b1, 20, ok);
        checkOutput("rx_rel2", ok, 1'b1);
        applyStimulus(1'b0, 3'd0, 8'h00, rd);
        checkOutput("rx_byte2", rd, 8'h33);

        $display("[TB] reset during transfer");
        applyStimulus(1'b1, 3'd6, 8'h01, rd);
        applyStimulus(1'b1, 3'd0, 8'h44, rd);
        waitDav(1'b0, 10, ok);
        checkOutput("rs_dav_low", ok, 1'b1);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("rs_async", {pc_oe, pa_oe, bus.irq, bus.bus_rdata}, 19'h0);
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(1'b0, 3'd7, 8'h00, rd);
        checkOutput("rs_hsstat", rd, 8'h00);
        applyStimulus(1'b0, 3'd6, 8'h00, rd);
        checkOutput("rs_hsctl", rd, 8'h00);

`ifdef HS_TIMEOUT_EN
        $display("[TB] handshake timeout");
        pc_in = 2'b11;
        applyStimulus(1'b1, 3'd6, 8'h01, rd);
        applyStimulus(1'b1, 3'd0, 8'h66, rd);
        @(posedge clock);
        @(posedge clock);
        #1;
        checkOutput("to_enter_dav", pc_out[1], 1'b0);
        repeat (TO_CYCLES - 1) @(posedge clock);
        #1;
        checkOutput("to_before_dav", pc_out[1], 1'b0);
        @(posedge clock);
        #1;
        checkOutput("to_hit_dav", pc_out[1], 1'b1);
        checkOutput("to_irq", bus.irq, 1'b1);
        applyStimulus(1'b0, 3'd7, 8'h00, rd);
        checkOutput("to_hsstat", rd, 8'h04);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, failCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/tcbm_pio_hs.md
Name: tcbm_pio_hs

Overview:
- Synchronous, parametrised successor to the drive-side 6523 emulation used on the TCBM paddle.
- Provides three 6523-style ports (A, B, C) with data and DDR registers behind an 8-register window.
- Adds a hardware DAV/ACK byte-handshake engine on port A / port C, so the host CPU no longer bit-bangs the protocol.
- Sits between the PLA-style address decoder (which supplies bus_sel) and the TCBM connector pins; all state lives in the single clock domain.

Parameters:
- PA_WIDTH, 8, port A width (1..8, mapped to data[PA_WIDTH-1:0]).
- PB_WIDTH, 2, port B width (mapped to data[PB_WIDTH-1:0]).
- PC_WIDTH, 2, port C width (mapped to data[7:8-PC_WIDTH]); minimum 2.
- SYNC_STAGES, 2, flip-flop stages on every pin input (min 2).
- TIMEOUT_CYCLES, 1023, handshake wait limit; used only with HS_TIMEOUT_EN.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- bus_sel  in  1  chip select from decoder, level; one access per assertion.
- bus_we  in  1  1=write, 0=read; sampled with bus_sel.
- bus_rs  in  3  register select.
- bus_wdata  in  8  write data.
- bus_rdata  out  8  registered read data.
- pa_in/pa_out/pa_oe  in/out/out  PA_WIDTH  port A pin in, drive value, drive enable.
- pb_in/pb_out/pb_oe  in/out/out  PB_WIDTH  port B pin in, drive value, drive enable.
- pc_in/pc_out/pc_oe  in/out/out  PC_WIDTH  port C pin in, drive value, drive enable; top bit = DAV, next = ACK.
- irq  out  1  high while HSSTAT.done or HSSTAT.timeout is set.

Behaviour:
- Access detect: the access fires on the first clock with bus_sel=1 after a cycle with bus_sel=0. It is ignored if bus_sel stays high.
- Write commits at that edge. bus_rdata is updated at the same edge, is valid the following cycle, and is held until the next access.
- Register map: 0 PRA, 1 PRB, 2 PRC, 3 DDRA, 4 DDRB, 5 DDRC, 6 HSCTL, 7 HSSTAT. Unimplemented bits read 0.
- Port read value = (synced_in & ~DDR) | (PR & DDR). pX_out = PR; pX_oe = DDR.
- HSCTL: bit0 en, bit1 mode (0 = transmit, 1 = receive).
- With en=1, the engine overrides port C: DAV is forced pc_oe=1 driven by the engine; ACK is forced pc_oe=0. In receive mode the whole of port A oe is forced to 0.
- HSSTAT: bit0 busy, bit1 done, bit2 timeout. Reading HSSTAT clears done and timeout.
- Transmit FSM:
  - IDLE: a PRA write with en=1 and mode=0 goes to SETUP.
  - SETUP: one cycle, data driven, DAV=1, then ASSERT.
  - ASSERT: DAV=0, then WAIT_ACK.
  - WAIT_ACK: waits for synced ACK=0, then RELEASE.
  - RELEASE: DAV=1, then WAIT_ACKR.
  - WAIT_ACKR: waits for synced ACK=1, then DONE.
  - DONE: sets done, returns to IDLE.
  - busy=1 in every state except IDLE.
- Receive FSM (armed while en=1, mode=1, done=0):
  - R_WAIT: waits for synced ACK(peer strobe)=0, latches synced pa_in into RXA, then R_ACK.
  - R_ACK: DAV=0, waits for peer strobe=1.
  - R_REL: DAV=1, sets done, parks.
  - A PRA read returns RXA, clears done and re-arms. A second byte is never accepted before the first is read.
- PRA write while busy: dropped, no state change.
- Clearing HSCTL.en mid-transfer: aborts to IDLE next cycle; DAV follows PRC/DDRC again; done is not set.
- Simultaneous HSSTAT read and done set: the set wins, so done reads 0 in that access and 1 in the next.
- Reset values: all PR/DDR = 0, HSCTL = 0, HSSTAT = 0, RXA = 0, bus_rdata = 0, all oe = 0, FSM = IDLE, irq = 0. Reset mid-operation returns to IDLE immediately (asynchronously).

Optional Feature:
- HS_TIMEOUT_EN defined: a counter runs in WAIT_ACK, WAIT_ACKR, R_ACK.
  - On reaching TIMEOUT_CYCLES: DAV=1, timeout=1, go to IDLE (transmit) or re-arm (receive).
  - The counter clears on every state change.
- Undefined: no counter; waits are unbounded; HSSTAT.bit2 reads 0.

Test Plan:
- Reset, then read all 8 registers -> every bus_rdata = 0x00; all oe = 0; irq = 0.
- Write DDRA=0xF0, PRA=0xA5, pa_in=0x3C, read PRA -> 0xAC; pa_out=0xA5; pa_oe=0xF0.
- HSCTL=0x01, DDRA=0xFF, PRA=0x5A; peer pulls ACK low 10 cycles after DAV falls, releases 5 cycles after DAV rises -> DAV falls 2 cycles after the write (SETUP then ASSERT); done=1; irq=1; HSSTAT read = 0x02, then 0x00.
- HSCTL=0x03, peer drives pa_in=0x77 and strobes twice without a PRA read -> first byte acked; second strobe gets no DAV low until PRA read returns 0x77.
- Transmit started, reset asserted while in WAIT_ACK -> FSM IDLE, pc_oe=0, HSSTAT=0 same cycle.
- HS_TIMEOUT_EN with TIMEOUT_CYCLES=16, ACK held high -> DAV back high 16 cycles after entering WAIT_ACK; HSSTAT=0x04; irq=1.
